// File: rtl/dpu_pp_pkg.sv
// -----------------------------------------------------------------------------
// dpu_pp_pkg
//   Shared types and default widths for the post-process pipe.
//   act_mode_e : activation selector carried with each beat (code 3 acts as
//                LINEAR).
//   PP_*       : default lane count and datapath widths.
// -----------------------------------------------------------------------------
package dpu_pp_pkg;

    typedef enum logic [1:0] {
        ACT_LINEAR = 2'd0,
        ACT_LEAKY  = 2'd1,
        ACT_RELU   = 2'd2
    } act_mode_e;

    localparam int PP_LANES   = 32;
    localparam int PP_ACC_W   = 32;
    localparam int PP_SCALE_W = 16;
    localparam int PP_SCALE_Q = 16;
    localparam int PP_OUT_W   = 8;

endpackage

// File: rtl/pp_lane.sv
// -----------------------------------------------------------------------------
// pp_lane
//   One lane of the post-process datapath: S1 bias add, S2 activation,
//   S3 requantize with optional round-half-up and saturation. Every register
//   advances together when i_en is high and holds otherwise; beat valids are
//   tracked by the parent.
// Ports
//   clk, rst_n     clock, asynchronous active-low reset
//   i_en           global advance
//   i_acc, i_bias  signed accumulator and bias (ACC_W)
//   i_scale        unsigned scale (SCALE_W, SCALE_Q fractional bits)
//   i_mode         activation mode, travels with the beat
//   i_round        round half-up enable, travels with the beat
//   o_act          S3 post-activation value
//   o_result       S3 requantized, clamped value (OUT_W)
//   o_sat          S3 clamp flag
//   o_sat_nxt      clamp flag of the value about to load into S3
// -----------------------------------------------------------------------------
module pp_lane
    import dpu_pp_pkg::*;
#(
    parameter int ACC_W   = PP_ACC_W,
    parameter int SCALE_W = PP_SCALE_W,
    parameter int SCALE_Q = PP_SCALE_Q,
    parameter int OUT_W   = PP_OUT_W
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               i_en,
    input  logic [ACC_W-1:0]   i_acc,
    input  logic [ACC_W-1:0]   i_bias,
    input  logic [SCALE_W-1:0] i_scale,
    input  logic [1:0]         i_mode,
    input  logic               i_round,
    output logic [ACC_W-1:0]   o_act,
    output logic [OUT_W-1:0]   o_result,
    output logic               o_sat,
    output logic               o_sat_nxt
);

    // Product width holds any signed ACC_W x unsigned SCALE_W product plus
    // the rounding constant without overflow.
    localparam int PW = ACC_W + SCALE_W + 1;
    localparam logic signed [PW-1:0] MAX_V = (PW'(1) << (OUT_W - 1)) - PW'(1);
    localparam logic signed [PW-1:0] MIN_V = ~MAX_V;
    localparam logic signed [PW-1:0] RND_V = PW'(1) << (SCALE_Q - 1);

    // S1 registers
    logic [ACC_W-1:0]   r_s1_b;
    logic [SCALE_W-1:0] r_s1_scale;
    logic [1:0]         r_s1_mode;
    logic               r_s1_round;
    // S2 registers
    logic [ACC_W-1:0]   r_s2_a;
    logic [SCALE_W-1:0] r_s2_scale;
    logic               r_s2_round;
    // S3 registers
    logic [ACC_W-1:0]   r_s3_act;
    logic [OUT_W-1:0]   r_s3_res;
    logic               r_s3_sat;

    logic [ACC_W-1:0]      w_act;
    logic signed [PW-1:0]  w_a_ext;
    logic signed [PW-1:0]  w_s_ext;
    logic signed [PW-1:0]  w_rnd;
    logic signed [PW-1:0]  w_p;
    logic signed [PW-1:0]  w_r;
    logic [OUT_W-1:0]      w_res;
    logic                  w_sat;

    // S2 activation. LEAKY approximates a 0.09375 slope with two shifts.
    always_comb begin
        w_act = r_s1_b;
        case (act_mode_e'(r_s1_mode))
            ACT_RELU: begin
                if (r_s1_b[ACC_W-1]) w_act = '0;
            end
            ACT_LEAKY: begin
                if (r_s1_b[ACC_W-1])
                    w_act = ($signed(r_s1_b) >>> 3) - ($signed(r_s1_b) >>> 5);
            end
            default: ;
        endcase
    end

    // S3 requantize: signed multiply by zero-extended scale, optional
    // round half-up, arithmetic shift (floor), then clamp.
    always_comb begin
        w_a_ext = PW'($signed(r_s2_a));
        w_s_ext = $signed(PW'(r_s2_scale));
        w_rnd   = r_s2_round ? RND_V : '0;
        w_p     = (w_a_ext * w_s_ext) + w_rnd;
        w_r     = w_p >>> SCALE_Q;
        w_res   = w_r[OUT_W-1:0];
        w_sat   = 1'b0;
        if (w_r > MAX_V) begin
            w_res = MAX_V[OUT_W-1:0];
            w_sat = 1'b1;
        end else if (w_r < MIN_V) begin
            w_res = MIN_V[OUT_W-1:0];
            w_sat = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1_b     <= '0;
            r_s1_scale <= '0;
            r_s1_mode  <= '0;
            r_s1_round <= 1'b0;
            r_s2_a     <= '0;
            r_s2_scale <= '0;
            r_s2_round <= 1'b0;
            r_s3_act   <= '0;
            r_s3_res   <= '0;
            r_s3_sat   <= 1'b0;
        end else if (i_en) begin
            r_s1_b     <= i_acc + i_bias;
            r_s1_scale <= i_scale;
            r_s1_mode  <= i_mode;
            r_s1_round <= i_round;
            r_s2_a     <= w_act;
            r_s2_scale <= r_s1_scale;
            r_s2_round <= r_s1_round;
            r_s3_act   <= r_s2_a;
            r_s3_res   <= w_res;
            r_s3_sat   <= w_sat;
        end
    end

    assign o_act     = r_s3_act;
    assign o_result  = r_s3_res;
    assign o_sat     = r_s3_sat;
    assign o_sat_nxt = w_sat;

endmodule

// File: rtl/post_process_pipe.sv
// -----------------------------------------------------------------------------
// post_process_pipe
//   Elastic 3-stage post-process pipe (bias add, activation, requantize)
//   between the MAC accumulator drain and the write-back buffer.
//
// Handshake (both sides): a beat transfers on a cycle where valid and ready
//   are both high. The pipe stalls globally: adv = !out_valid | out_ready,
//   in_ready = adv. With adv low every stage holds, so the output beat stays
//   stable until taken; with adv high all stages shift, bubbles included.
//
// Ports
//   clk, rst_n               clock, asynchronous active-low reset
//   in_valid/in_ready        input handshake
//   acc_flat, bias_flat      per-lane signed accumulator and bias
//   scale_flat               per-lane unsigned scale
//   act_mode, round_en       per-beat controls, sampled with the beat
//   out_valid/out_ready      output handshake
//   result_flat              per-lane requantized result
//   act_flat                 per-lane post-activation value, same beat
//   sat_mask                 per-lane clamp flags of the current output beat
//   sat_sticky, sat_clr      clamp-seen flag and its clear
//   beat_cnt                 wrapping count of output handshakes
// -----------------------------------------------------------------------------
module post_process_pipe
    import dpu_pp_pkg::*;
#(
    parameter int LANES   = PP_LANES,
    parameter int ACC_W   = PP_ACC_W,
    parameter int SCALE_W = PP_SCALE_W,
    parameter int SCALE_Q = PP_SCALE_Q,
    parameter int OUT_W   = PP_OUT_W
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [LANES*ACC_W-1:0]   acc_flat,
    input  logic [LANES*ACC_W-1:0]   bias_flat,
    input  logic [LANES*SCALE_W-1:0] scale_flat,
    input  logic [1:0]               act_mode,
    input  logic                     round_en,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [LANES*OUT_W-1:0]   result_flat,
    output logic [LANES*ACC_W-1:0]   act_flat,
    output logic [LANES-1:0]         sat_mask,
    output logic                     sat_sticky,
    input  logic                     sat_clr,
    output logic [31:0]              beat_cnt
);

    logic             r_v1;
    logic             r_v2;
    logic             r_v3;
    logic             r_sat_sticky;
    logic [31:0]      r_beat_cnt;
    logic             w_adv;
    logic [LANES-1:0] w_sat_nxt;

    assign w_adv = !r_v3 || out_ready;

    generate
        for (genvar g = 0; g < LANES; g++) begin : g_lane
            pp_lane #(
                .ACC_W   (ACC_W),
                .SCALE_W (SCALE_W),
                .SCALE_Q (SCALE_Q),
                .OUT_W   (OUT_W)
            ) u_lane (
                .clk       (clk),
                .rst_n     (rst_n),
                .i_en      (w_adv),
                .i_acc     (acc_flat[g*ACC_W +: ACC_W]),
                .i_bias    (bias_flat[g*ACC_W +: ACC_W]),
                .i_scale   (scale_flat[g*SCALE_W +: SCALE_W]),
                .i_mode    (act_mode),
                .i_round   (round_en),
                .o_act     (act_flat[g*ACC_W +: ACC_W]),
                .o_result  (result_flat[g*OUT_W +: OUT_W]),
                .o_sat     (sat_mask[g]),
                .o_sat_nxt (w_sat_nxt[g])
            );
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_v1 <= 1'b0;
            r_v2 <= 1'b0;
            r_v3 <= 1'b0;
        end else if (w_adv) begin
            r_v1 <= in_valid;
            r_v2 <= r_v1;
            r_v3 <= r_v2;
        end
    end

    // Sticky sets when a valid clamped beat loads into S3; set beats clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sat_sticky <= 1'b0;
        end else if (w_adv && r_v2 && (|w_sat_nxt)) begin
            r_sat_sticky <= 1'b1;
        end else if (sat_clr) begin
            r_sat_sticky <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_beat_cnt <= '0;
        end else if (r_v3 && out_ready) begin
            r_beat_cnt <= r_beat_cnt + 32'd1;
        end
    end

    assign in_ready   = w_adv;
    assign out_valid  = r_v3;
    assign sat_sticky = r_sat_sticky;
    assign beat_cnt   = r_beat_cnt;

endmodule
